// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum accumulator: FSM state encoding and width constants.
// Pure declarations; no logic, no latency, no flow control.
package sum_acc_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_ACC_WIDTH   = 40;
  localparam int DEF_COUNT_WIDTH = 8;

  localparam logic [1:0] ENC_IDLE  = 2'b00;
  localparam logic [1:0] ENC_ACCUM = 2'b01;
  localparam logic [1:0] ENC_DONE  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_ACCUM = ENC_ACCUM,
    ST_DONE  = ENC_DONE
  } state_e;

endpackage

// File: rtl/sum_acc_if.sv
// Handshake bundle between the adder output stage, the accumulator and the result consumer.
// Input side is valid/ready; the result is held valid until out_ready.
interface sum_acc_if import sum_acc_pkg::*; #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) ();

  logic                   start;
  logic [COUNT_WIDTH-1:0] len;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_sum;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_acc;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   out_ovf;
  logic                   busy;

  modport master (
    output start, len, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf, busy
  );

endinterface

// File: rtl/sum_acc_ctrl.sv
// Burst sequencer: IDLE/ACCUM/DONE FSM plus sample counter; emits clear and beat strobes.
// DONE is entered the cycle after the last beat; in_ready only in ACCUM, result held until out_ready.
module sum_acc_ctrl import sum_acc_pkg::*; #(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [COUNT_WIDTH-1:0] len_i,
  input  logic                   in_valid_i,
  input  logic                   out_ready_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  output logic                   busy_o,
  output logic                   beat_o,
  output logic                   clear_o,
  output logic [COUNT_WIDTH-1:0] count_o
);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] count_inc;

  assign count_inc = count_q + COUNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (beat_o && (count_inc == len_q)) state_d = ST_DONE;
      ST_DONE:  if (out_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == ST_ACCUM);
    out_valid_o = (state_q == ST_DONE);
    busy_o      = (state_q != ST_IDLE);
    beat_o      = in_ready_o && in_valid_i;
    clear_o     = (state_q == ST_IDLE) && start_i;
  end

  // len is only captured on an accepted start; count tracks accepted beats
  always_comb begin
    len_d   = len_q;
    count_d = count_q;
    if (clear_o) begin
      len_d   = len_i;
      count_d = '0;
    end else if (beat_o) begin
      count_d = count_inc;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a burst of unsigned adder sums into a wide total; result valid the cycle after the last beat.
// Result held until out_ready; SUM_ACC_SAT_EN selects clamp-on-carry instead of modulo wrap.
module sum_accumulator import sum_acc_pkg::*; #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input logic     clk,
  input logic     rst_n,
  sum_acc_if.slave bus
);

  logic                 beat;
  logic                 clear;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 carry;

  sum_acc_ctrl #(.COUNT_WIDTH(COUNT_WIDTH)) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (bus.start),
    .len_i       (bus.len),
    .in_valid_i  (bus.in_valid),
    .out_ready_i (bus.out_ready),
    .in_ready_o  (bus.in_ready),
    .out_valid_o (bus.out_valid),
    .busy_o      (bus.busy),
    .beat_o      (beat),
    .clear_o     (clear),
    .count_o     (bus.out_count)
  );

  assign sum_ext = {1'b0, acc_q} + (ACC_WIDTH+1)'(bus.in_sum);
  assign carry   = sum_ext[ACC_WIDTH];

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (beat) begin
      ovf_d = ovf_q | carry;
`ifdef SUM_ACC_SAT_EN
      // once clamped the total stays pinned for the remainder of the burst
      acc_d = (ovf_q | carry) ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
      acc_d = sum_ext[ACC_WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out_acc = acc_q;
  assign bus.out_ovf = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: vector table, hand-written corner sequences and random bursts vs a sum model.
// Expectations follow SUM_ACC_SAT_EN when it is defined for the build.
module tb_sum_accumulator;
  import sum_acc_pkg::*;

  localparam int W   = 32;
  localparam int AW  = 40;
  localparam int CW  = 8;
  localparam int AW2 = 33;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sum_acc_if #(.WIDTH(W), .ACC_WIDTH(AW),  .COUNT_WIDTH(CW)) b40 ();
  sum_acc_if #(.WIDTH(W), .ACC_WIDTH(AW2), .COUNT_WIDTH(CW)) b33 ();

  sum_accumulator #(.WIDTH(W), .ACC_WIDTH(AW),  .COUNT_WIDTH(CW)) dut40 (.clk(clk), .rst_n(rst_n), .bus(b40));
  sum_accumulator #(.WIDTH(W), .ACC_WIDTH(AW2), .COUNT_WIDTH(CW)) dut33 (.clk(clk), .rst_n(rst_n), .bus(b33));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Final total is the plain sum, folded to the accumulator width.
  function automatic logic [63:0] model_acc(input logic [63:0] total, input int aw);
    logic [63:0] lim;
    lim = 64'd1 << aw;
`ifdef SUM_ACC_SAT_EN
    if (total >= lim) return lim - 64'd1;
`endif
    return total & (lim - 64'd1);
  endfunction

  logic [31:0] sum_q[$];
  logic [39:0] g_acc;
  logic [7:0]  g_cnt;
  logic        g_ovf;

  task automatic run_burst(input logic [7:0] len, input int gap, input int hold, input string tag,
                           output logic [39:0] acc, output logic [7:0] cnt, output logic ovf);
    logic [63:0] total;
    total = 0;
    b40.start = 1'b1;
    b40.len   = len;
    @(negedge clk);
    b40.start = 1'b0;
    b40.len   = 8'($urandom);
    chk({tag, " in_ready after start"}, 64'(b40.in_ready), 64'(len != 0));
    for (int i = 0; i < int'(len); i++) begin
      for (int g = 0; g < gap; g++) begin
        b40.in_valid = 1'b0;
        b40.in_sum   = $urandom;
        @(negedge clk);
        chk({tag, " stall count"}, 64'(b40.out_count), 64'(i));
        chk({tag, " stall acc"}, 64'(b40.out_acc), model_acc(total, AW));
      end
      b40.in_valid = 1'b1;
      b40.in_sum   = sum_q[i];
      total        = total + 64'(sum_q[i]);
      @(negedge clk);
      b40.in_valid = 1'b0;
      b40.in_sum   = $urandom;
      chk({tag, " out_valid timing"}, 64'(b40.out_valid), 64'(i == int'(len) - 1));
    end
    if (len == 0) chk({tag, " out_valid len0"}, 64'(b40.out_valid), 64'd1);
    acc = b40.out_acc;
    cnt = b40.out_count;
    ovf = b40.out_ovf;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold out_valid"}, 64'(b40.out_valid), 64'd1);
      chk({tag, " hold in_ready"}, 64'(b40.in_ready), 64'd0);
      chk({tag, " hold acc"}, 64'(b40.out_acc), model_acc(total, AW));
    end
    b40.out_ready = 1'b1;
    @(negedge clk);
    b40.out_ready = 1'b0;
    chk({tag, " released out_valid"}, 64'(b40.out_valid), 64'd0);
    chk({tag, " released busy"}, 64'(b40.busy), 64'd0);
  endtask

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][31:0] sums;
    logic [39:0]      exp_acc;
    logic [7:0]       exp_cnt;
    logic             exp_ovf;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [63:0] total;
    logic [7:0]  rlen;
    logic [31:0] v;
    logic [63:0] exp33;

    tbl[0] = '{len: 8'd3, sums: {32'd0, 32'd3, 32'd2, 32'd1},
               exp_acc: 40'd6, exp_cnt: 8'd3, exp_ovf: 1'b0};
    tbl[1] = '{len: 8'd3, sums: {32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
               exp_acc: 40'h2_FFFF_FFFD, exp_cnt: 8'd3, exp_ovf: 1'b0};
    tbl[2] = '{len: 8'd1, sums: {32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF},
               exp_acc: 40'hDE_AD_BE_EF, exp_cnt: 8'd1, exp_ovf: 1'b0};
    tbl[3] = '{len: 8'd4, sums: {32'd40, 32'd30, 32'd20, 32'd10},
               exp_acc: 40'd100, exp_cnt: 8'd4, exp_ovf: 1'b0};
    tbl[4] = '{len: 8'd0, sums: '0, exp_acc: 40'd0, exp_cnt: 8'd0, exp_ovf: 1'b0};

    {b40.start, b40.len, b40.in_valid, b40.in_sum, b40.out_ready} = '0;
    {b33.start, b33.len, b33.in_valid, b33.in_sum, b33.out_ready} = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", 64'(b40.in_ready), 64'd0);
    chk("reset out_valid", 64'(b40.out_valid), 64'd0);
    chk("reset busy", 64'(b40.busy), 64'd0);
    chk("reset acc", 64'(b40.out_acc), 64'd0);
    chk("reset count", 64'(b40.out_count), 64'd0);
    chk("reset ovf", 64'(b40.out_ovf), 64'd0);

    // reset in the middle of a burst
    b40.start = 1'b1; b40.len = 8'd4;
    @(negedge clk);
    b40.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b40.in_valid = 1'b1; b40.in_sum = 32'd100 + 32'(i);
      @(negedge clk);
    end
    b40.in_valid = 1'b0;
    chk("midburst busy before reset", 64'(b40.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midburst rst in_ready", 64'(b40.in_ready), 64'd0);
    chk("midburst rst busy", 64'(b40.busy), 64'd0);
    chk("midburst rst acc", 64'(b40.out_acc), 64'd0);
    chk("midburst rst count", 64'(b40.out_count), 64'd0);
    chk("midburst rst out_valid", 64'(b40.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      b40.in_valid = 1'b1;
      @(negedge clk);
      chk("after rst no result", 64'(b40.out_valid), 64'd0);
      chk("after rst idle", 64'(b40.busy), 64'd0);
    end
    b40.in_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      sum_q.delete();
      for (int j = 0; j < int'(tbl[i].len); j++) sum_q.push_back(tbl[i].sums[j]);
      run_burst(tbl[i].len, (i == 1) ? 2 : 0, 0, $sformatf("tbl%0d", i), g_acc, g_cnt, g_ovf);
      chk($sformatf("tbl%0d acc", i), 64'(g_acc), 64'(tbl[i].exp_acc));
      chk($sformatf("tbl%0d count", i), 64'(g_cnt), 64'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d ovf", i), 64'(g_ovf), 64'(tbl[i].exp_ovf));
    end

    // consumer stalls five cycles in DONE
    sum_q.delete(); sum_q.push_back(32'd100); sum_q.push_back(32'd200);
    run_burst(8'd2, 0, 5, "hold", g_acc, g_cnt, g_ovf);
    chk("hold acc", 64'(g_acc), 64'd300);

    // start during ACCUM and DONE must be ignored
    b40.start = 1'b1; b40.len = 8'd2;
    @(negedge clk);
    b40.start = 1'b0;
    b40.in_valid = 1'b1; b40.in_sum = 32'd7;
    @(negedge clk);
    b40.in_valid = 1'b0; b40.start = 1'b1; b40.len = 8'd9;
    @(negedge clk);
    b40.start = 1'b0;
    chk("ign start count", 64'(b40.out_count), 64'd1);
    chk("ign start acc", 64'(b40.out_acc), 64'd7);
    b40.in_valid = 1'b1; b40.in_sum = 32'd8;
    @(negedge clk);
    b40.in_valid = 1'b0;
    chk("ign start done", 64'(b40.out_valid), 64'd1);
    chk("ign start final count", 64'(b40.out_count), 64'd2);
    b40.start = 1'b1; b40.len = 8'd0;
    @(negedge clk);
    b40.start = 1'b0;
    chk("start in done acc", 64'(b40.out_acc), 64'd15);
    chk("start in done valid", 64'(b40.out_valid), 64'd1);
    b40.out_ready = 1'b1;
    @(negedge clk);
    b40.out_ready = 1'b0;
    chk("start in done released", 64'(b40.out_valid), 64'd0);

    // narrow accumulator: carry out of bit 32
    b33.start = 1'b1; b33.len = 8'd3;
    @(negedge clk);
    b33.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b33.in_valid = 1'b1; b33.in_sum = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    b33.in_valid = 1'b0;
`ifdef SUM_ACC_SAT_EN
    exp33 = 64'h1_FFFF_FFFF;
`else
    exp33 = 64'h0_FFFF_FFFD;
`endif
    chk("acc33 valid", 64'(b33.out_valid), 64'd1);
    chk("acc33 acc", 64'(b33.out_acc), exp33);
    chk("acc33 ovf", 64'(b33.out_ovf), 64'd1);
    chk("acc33 count", 64'(b33.out_count), 64'd3);
    b33.out_ready = 1'b1;
    @(negedge clk);
    b33.out_ready = 1'b0;
    b33.start = 1'b1; b33.len = 8'd1;
    @(negedge clk);
    b33.start = 1'b0;
    b33.in_valid = 1'b1; b33.in_sum = 32'd1;
    @(negedge clk);
    b33.in_valid = 1'b0;
    chk("acc33 next acc", 64'(b33.out_acc), 64'd1);
    chk("acc33 ovf cleared", 64'(b33.out_ovf), 64'd0);
    b33.out_ready = 1'b1;
    @(negedge clk);
    b33.out_ready = 1'b0;

    for (int r = 0; r < 25; r++) begin
      rlen  = 8'($urandom_range(12, 0));
      total = 0;
      sum_q.delete();
      for (int j = 0; j < int'(rlen); j++) begin
        v = ($urandom_range(1, 0) == 1) ? $urandom : 32'($urandom_range(1000, 0));
        sum_q.push_back(v);
        total = total + 64'(v);
      end
      run_burst(rlen, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), "rand", g_acc, g_cnt, g_ovf);
      chk("rand acc", 64'(g_acc), model_acc(total, AW));
      chk("rand count", 64'(g_cnt), 64'(rlen));
      chk("rand ovf", 64'(g_ovf), 64'(total >= (64'd1 << AW)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
